// File: rtl/mdu_seq_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU -> LO/HI), one trial subtract per clock.
// Optional build macro MDU_DIV_EARLY_OUT_EN: skip the iterations for divide-by-zero and |dividend| < |divisor|.
module mdu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is sampled only while busy=0; busy=1 from the issue edge until the
  // edge that raises done; done is a single-cycle pulse and is never high together with busy.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_dvd, mag_dsr;
  logic [WIDTH:0]   shifted, trial;
  logic             early_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    // Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1) read as unsigned: the magnitude fits.
    mag_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_dsr = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};

    // Compare is made on the registered magnitudes to keep abs+compare off the issue path,
    // so an early exit spends one DIV cycle before FIX.
`ifdef MDU_DIV_EARLY_OUT_EN
    early_exit = (cnt_q == CW'(WIDTH-1)) && (zero_q || (quo_q < dsr_q));
`else
    early_exit = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIV;
          cnt_d   = CW'(WIDTH-1);
          rem_d   = '0;
          quo_d   = mag_dvd;
          dsr_d   = mag_dsr;
          negq_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = is_signed && dividend[WIDTH-1];
          zero_d  = (divisor == '0);
          busy_d  = 1'b1;
        end
      end
      S_DIV: begin
        if (early_exit) begin
          state_d = S_FIX;
          rem_d   = quo_q;
          quo_d   = '0;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FIX: begin
        // With a zero divisor the remainder register ends up holding |dividend|,
        // so re-applying the dividend sign reproduces the raw dividend bits.
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        dbz_d     = zero_q;
        quo_out_d = zero_q ? '1 : (negq_q ? -quo_q : quo_q);
        rem_out_d = negr_q ? -rem_q : rem_q;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdu_seq_divider.sv
// Self-checking bench for mdu_seq_divider: directed cases, handshake scenarios, randomized
// operands against an arithmetic reference model with an expected-result queue.
module tb_mdu_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  mdu_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Truncating MIPS division on 64-bit integers; results packed as {quotient, remainder, dbz}.
  function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 1'b0};
  endfunction

  function automatic int exp_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = W + 1;
`ifdef MDU_DIV_EARLY_OUT_EN
    begin
      longint ma, mb;
      ma = s ? longint'($signed(a)) : longint'(a);
      mb = s ? longint'($signed(b)) : longint'(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (b == '0 || ma < mb) lat = 2;
    end
`else
    if (s === 1'bx || a === 'x || b === 'x) lat = 0;
`endif
    return lat;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is seen (or after a timeout).
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W:0] got, output int lat,
                       output logic bad_hs, output logic moved);
    logic [W-1:0] q0, r0;
    q0 = quotient;
    r0 = remainder;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bad_hs = !busy || done;
    moved  = 1'b0;
    lat    = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done && busy) bad_hs = 1'b1;
      if (!done && !busy) bad_hs = 1'b1;
      if (!done && (quotient !== q0 || remainder !== r0)) moved = 1'b1;
    end
    got = {quotient, remainder, div_by_zero};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%h r=%h dbz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    vec_t tab[10];
    logic [2*W:0] got, exp;
    int lat;
    logic hs, mv;
    tab[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tab[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tab[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tab[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tab[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    tab[5] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tab[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tab[7] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    tab[8] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    tab[9] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    foreach (tab[i]) begin
      exp_q.push_back({tab[i].q, tab[i].r, tab[i].z});
      do_op(tab[i].s, tab[i].a, tab[i].b, got, lat, hs, mv);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL directed_%0d result: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, got[2*W:W+1], got[W:1], got[0], exp[2*W:W+1], exp[W:1], exp[0]);
      end
      vectors++;
      if (lat !== exp_lat(tab[i].s, tab[i].a, tab[i].b)) begin
        miscompares++;
        $display("FAIL directed_%0d latency: %0d edges, required %0d",
                 i, lat, exp_lat(tab[i].s, tab[i].a, tab[i].b));
      end
      vectors++;
      if (hs !== 1'b0 || mv !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_%0d handshake: bad_hs=%b outputs_moved=%b, required 0 0", i, hs, mv);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [2*W:0] got;
    int lat, extra_done;
    logic hs, mv, busy_seen;
    fork
      do_op(1'b0, 32'd100, 32'd7, got, lat, hs, mv);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
      end
    join
    vectors++;
    if (got !== {32'd14, 32'd2, 1'b0} || lat !== exp_lat(1'b0, 32'd100, 32'd7)) begin
      miscompares++;
      $display("FAIL busy_ignore result: q=%0d r=%0d dbz=%b lat=%0d, required q=14 r=2 dbz=0 lat=%0d",
               got[2*W:W+1], got[W:1], got[0], lat, exp_lat(1'b0, 32'd100, 32'd7));
    end
    extra_done = 0;
    busy_seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) busy_seen = 1'b1;
    end
    vectors++;
    if (extra_done !== 0 || busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore queued: extra_done=%0d busy_seen=%b, required 0 0", extra_done, busy_seen);
    end
  endtask

  task automatic test_reset_mid_op;
    int dones;
    logic busy_seen;
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0 || dones !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_op: busy=%b done=%b q=%h r=%h dbz=%b early_dones=%0d, required all 0",
               busy, done, quotient, remainder, div_by_zero, dones);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_seen = 1'b1;
    end
    vectors++;
    if (dones !== 0 || busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: dones=%0d busy_seen=%b, required 0 0", dones, busy_seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W:0] got, exp;
    int lat;
    logic hs, mv;
    logic [W-1:0] a[3], b[3];
    logic s[3];
    a[0] = 32'd1000; b[0] = 32'd33; s[0] = 1'b0;
    a[1] = 32'hFFFF_FC18; b[1] = 32'd7; s[1] = 1'b1;
    a[2] = 32'd77; b[2] = 32'hFFFF_FFF6; s[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(s[i], a[i], b[i]));
      do_op(s[i], a[i], b[i], got, lat, hs, mv);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp || lat !== exp_lat(s[i], a[i], b[i]) || hs !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: q=%h r=%h dbz=%b lat=%0d hs=%b, required q=%h r=%h dbz=%b lat=%0d hs=0",
                 i, got[2*W:W+1], got[W:1], got[0], lat, hs, exp[2*W:W+1], exp[W:1], exp[0],
                 exp_lat(s[i], a[i], b[i]));
      end
    end
  endtask

  task automatic test_random;
    logic [2*W:0] got, exp;
    int lat;
    logic hs, mv, s;
    logic [W-1:0] a, b;
    for (int i = 0; i < 50; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = W'($urandom_range(0, 100));
        2:       a = -W'($urandom_range(1, 100));
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 15));
        3:       b = W'($urandom) >> $urandom_range(0, 31);
        4:       b = -W'($urandom_range(1, 300));
        default: b = W'($urandom);
      endcase
      exp_q.push_back(model(s, a, b));
      do_op(s, a, b, got, lat, hs, mv);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_%0d s=%b %h/%h: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, s, a, b, got[2*W:W+1], got[W:1], got[0], exp[2*W:W+1], exp[W:1], exp[0]);
      end
      vectors++;
      if (lat !== exp_lat(s, a, b) || hs !== 1'b0 || mv !== 1'b0) begin
        miscompares++;
        $display("FAIL random_%0d timing: lat=%0d hs=%b moved=%b, required lat=%0d 0 0",
                 i, lat, hs, mv, exp_lat(s, a, b));
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
